// File: rtl/riscv_branch_pkg.sv
// Shared branch-unit definitions: funct3 encodings, predictor counter type and training rule.
package riscv_branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // 2-bit saturating counter update for one resolved branch
  function automatic ctr_t ctr_train(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != CTR_SNT) nxt = ctr_t'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// Combinational branch condition evaluator; jumps are always taken, funct3 010/011 flagged illegal.
module branch_cmp_core
  import riscv_branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic            Jump,
  input  logic            BrUn,
  output logic            taken,
  output logic            illegal
);

  logic eq;
  logic lt_s;
  logic lt_u;
  logic lt;
  logic use_unsigned;

  // Magnitude compare; funct3[1] marks the BLTU/BGEU encodings
  always_comb begin
    eq           = (a == b);
    lt_s         = ($signed(a) < $signed(b));
    lt_u         = (a < b);
    use_unsigned = BrUn | funct3[1];
    lt           = use_unsigned ? lt_u : lt_s;
  end

  // funct3 decode with jump override
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (Jump) begin
      taken = 1'b1;
    end else begin
      case (funct3)
        F3_BEQ:           taken = eq;
        F3_BNE:           taken = ~eq;
        F3_BLT, F3_BLTU:  taken = lt;
        F3_BGE, F3_BGEU:  taken = ~lt;
        default:          illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolver with a direct-mapped 2-bit BHT read by IF and registered results for flush logic.
module branch_resolve_bht
  import riscv_branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter ctr_t        CTR_INIT    = CTR_WNT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_kill,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic            Jump,
  input  logic            BrUn,
  input  logic            ex_pred_taken,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic [XLEN-1:0] res_redirect,
  output logic            res_illegal,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int unsigned IDX_W  = $clog2(BHT_ENTRIES);
  localparam int unsigned STAT_W = 32;

  ctr_t bht [BHT_ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             cmp_taken;
  logic             cmp_illegal;
  logic             fire;
  logic             train_en;
  logic             mispredict_c;
  logic [XLEN-1:0]  redirect_c;
  logic             cnt_mispred;
  logic             unused_if_pc_bits;

  branch_cmp_core #(
    .XLEN(XLEN)
  ) u_cmp (
    .a       (a),
    .b       (b),
    .funct3  (funct3),
    .Jump    (Jump),
    .BrUn    (BrUn),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  // Word-aligned PC bits select the predictor entry
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // High PC bits and byte offset do not take part in indexing
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  // IF prediction reads the array directly, so a same-cycle EX update is not visible yet
  assign if_pred_taken = bht[if_idx][1];

  // EX-cycle result and qualifier terms
  always_comb begin
    fire         = ex_valid & ~ex_kill;
    train_en     = fire & ~Jump & ~cmp_illegal;
    mispredict_c = cmp_taken ^ ex_pred_taken;
    redirect_c   = cmp_taken ? ex_target : (ex_pc + XLEN'(4));
    cnt_mispred  = fire & mispredict_c & ~cmp_illegal;
  end

  // Predictor table: reset to CTR_INIT, train legal conditional branches
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht[i] <= CTR_INIT;
      end
    end else if (train_en) begin
      bht[ex_idx] <= ctr_train(bht[ex_idx], cmp_taken);
    end
  end

  // Result registers: one-cycle valid pulse, payload holds between fires
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_mispredict <= 1'b0;
      res_redirect   <= '0;
      res_illegal    <= 1'b0;
    end else begin
      res_valid <= fire;
      if (fire) begin
        res_taken      <= cmp_taken;
        res_mispredict <= mispredict_c;
        res_redirect   <= redirect_c;
        res_illegal    <= cmp_illegal;
      end
    end
  end

  // Wrapping event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (train_en)    stat_branches <= stat_branches + STAT_W'(1);
      if (cnt_mispred) stat_mispred  <= stat_mispred + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Scoreboard bench for branch_resolve_bht: expected results queued at drive, compared one cycle later.
module tb_branch_resolve_bht;
  import riscv_branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_kill;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  funct3;
  logic        Jump;
  logic        BrUn;
  logic        ex_pred_taken;
  logic        res_valid;
  logic        res_taken;
  logic        res_mispredict;
  logic [31:0] res_redirect;
  logic        res_illegal;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  typedef struct packed {
    logic        taken;
    logic        mispred;
    logic [31:0] redirect;
    logic        illegal;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [1:0]  m_bht [64];
  logic [31:0] m_br;
  logic [31:0] m_mp;

  always #5 clk = ~clk;

  branch_resolve_bht #(
    .XLEN        (32),
    .BHT_ENTRIES (64),
    .CTR_INIT    (2'b01)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_kill        (ex_kill),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .a              (a),
    .b              (b),
    .funct3         (funct3),
    .Jump           (Jump),
    .BrUn           (BrUn),
    .ex_pred_taken  (ex_pred_taken),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .res_mispredict (res_mispredict),
    .res_redirect   (res_redirect),
    .res_illegal    (res_illegal),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_br = 32'd0;
    m_mp = 32'd0;
    sb.delete();
  endtask

  // Drive one EX instruction; caller supplies the expected outcome
  task automatic drive_ex(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [31:0] aa, input logic [31:0] bb,
                          input logic [2:0] f3, input logic j, input logic bu,
                          input logic pred, input logic exp_taken, input logic exp_ill);
    exp_t       e;
    logic [5:0] idx;
    ex_valid      = 1'b1;
    ex_kill       = 1'b0;
    ex_pc         = pc;
    ex_target     = tgt;
    a             = aa;
    b             = bb;
    funct3        = f3;
    Jump          = j;
    BrUn          = bu;
    ex_pred_taken = pred;
    e.taken    = exp_taken;
    e.mispred  = exp_taken ^ pred;
    e.redirect = exp_taken ? tgt : pc + 32'd4;
    e.illegal  = exp_ill;
    sb.push_back(e);
    idx = pc[7:2];
    if (!j && !exp_ill) begin
      if (exp_taken) begin
        if (m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'b01;
      end else begin
        if (m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'b01;
      end
      m_br = m_br + 32'd1;
    end
    if (!exp_ill && (exp_taken ^ pred)) m_mp = m_mp + 32'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    ex_kill  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'hFC;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if ({res_valid, res_taken, res_mispredict, res_redirect, res_illegal} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_res: got %0h expected 0",
               {res_valid, res_taken, res_mispredict, res_redirect, res_illegal});
    end
    vectors++;
    if ({stat_branches, stat_mispred} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_stats: got %0h/%0h expected 0/0", stat_branches, stat_mispred);
    end
    for (int i = 0; i < 3; i++) begin
      if_pc = pcs[i];
      #1;
      vectors++;
      if (if_pred_taken !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_pred[%0h]: got %b expected 0", pcs[i], if_pred_taken);
      end
    end
  endtask

  task automatic test_compare_matrix();
    logic [31:0] ta [7];
    logic [31:0] tb_ [7];
    logic [2:0]  tf [7];
    logic        tu [7];
    logic        tx [7];
    logic [35:0] act;
    logic [35:0] expv;
    exp_t        e;
    ta[0]=32'hFFFFFFFF; tb_[0]=32'h1;  tf[0]=3'b100; tu[0]=1'b0; tx[0]=1'b1;
    ta[1]=32'hFFFFFFFF; tb_[1]=32'h1;  tf[1]=3'b100; tu[1]=1'b1; tx[1]=1'b0;
    ta[2]=32'hFFFFFFFF; tb_[2]=32'h1;  tf[2]=3'b110; tu[2]=1'b0; tx[2]=1'b0;
    ta[3]=32'hFFFFFFFF; tb_[3]=32'h1;  tf[3]=3'b101; tu[3]=1'b0; tx[3]=1'b0;
    ta[4]=32'hFFFFFFFF; tb_[4]=32'h1;  tf[4]=3'b111; tu[4]=1'b0; tx[4]=1'b1;
    ta[5]=32'h10;       tb_[5]=32'h10; tf[5]=3'b000; tu[5]=1'b0; tx[5]=1'b1;
    ta[6]=32'h10;       tb_[6]=32'h10; tf[6]=3'b001; tu[6]=1'b0; tx[6]=1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_ex(32'h2010 + 32'(i) * 32'd4, 32'h8000, ta[i], tb_[i], tf[i], 1'b0, tu[i],
               1'b0, tx[i], 1'b0);
      step();
      e    = sb.pop_front();
      act  = {res_valid, res_taken, res_mispredict, res_redirect, res_illegal};
      expv = {1'b1, e.taken, e.mispred, e.redirect, e.illegal};
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL matrix[%0d]: got %0h expected %0h", i, act, expv);
      end
    end
    vectors++;
    if (stat_branches !== m_br) begin
      miscompares++;
      $display("FAIL matrix_stat_branches: got %0d expected %0d", stat_branches, m_br);
    end
  endtask

  task automatic test_training();
    logic [35:0] act;
    logic [35:0] expv;
    exp_t        e;
    logic        pred;
    logic        want [6];
    // taken x4 (saturate), then not-taken x2: prediction 1,1,1,1 then 1, 0
    want[0]=1'b1; want[1]=1'b1; want[2]=1'b1; want[3]=1'b1; want[4]=1'b1; want[5]=1'b0;
    if_pc = 32'h100;
    for (int i = 0; i < 6; i++) begin
      pred = m_bht[0][1];
      if (i < 4) drive_ex(32'h100, 32'h300, 32'h5, 32'h5, F3_BEQ, 1'b0, 1'b0, pred, 1'b1, 1'b0);
      else       drive_ex(32'h100, 32'h300, 32'h5, 32'h5, F3_BNE, 1'b0, 1'b0, pred, 1'b0, 1'b0);
      step();
      e    = sb.pop_front();
      act  = {res_valid, res_taken, res_mispredict, res_redirect, res_illegal};
      expv = {1'b1, e.taken, e.mispred, e.redirect, e.illegal};
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL train_res[%0d]: got %0h expected %0h", i, act, expv);
      end
      vectors++;
      if (if_pred_taken !== want[i]) begin
        miscompares++;
        $display("FAIL train_pred[%0d]: got %b expected %b", i, if_pred_taken, want[i]);
      end
    end
  endtask

  task automatic test_jump_redirect();
    logic [35:0] act;
    exp_t        e;
    logic [31:0] br_before;
    logic [31:0] mp_before;
    logic        pred0;
    br_before = m_br;
    mp_before = m_mp;
    pred0     = m_bht[0][1];
    drive_ex(32'h200, 32'h40, 32'h1, 32'h2, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    e   = sb.pop_front();
    act = {res_valid, res_taken, res_mispredict, res_redirect, res_illegal};
    vectors++;
    if (act !== {1'b1, 1'b1, 1'b1, 32'h40, 1'b0}) begin
      miscompares++;
      $display("FAIL jump_res: got %0h expected %0h", act, {1'b1, 1'b1, 1'b1, 32'h40, 1'b0});
    end
    vectors++;
    if (stat_branches !== br_before || stat_mispred !== mp_before + 32'd1) begin
      miscompares++;
      $display("FAIL jump_stats: got %0d/%0d expected %0d/%0d",
               stat_branches, stat_mispred, br_before, mp_before + 32'd1);
    end
    if_pc = 32'h200;
    #1;
    vectors++;
    if (if_pred_taken !== pred0) begin
      miscompares++;
      $display("FAIL jump_no_train: got %b expected %b", if_pred_taken, pred0);
    end
    drive_ex(32'hFFFFFFFC, 32'h1234, 32'h1, 32'h2, F3_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    e = sb.pop_front();
    vectors++;
    if (res_redirect !== 32'h0 || res_taken !== 1'b0 || res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL redirect_wrap: got %0h taken %b expected 0 taken 0", res_redirect, res_taken);
    end
  endtask

  task automatic test_kill_illegal_collision();
    logic [35:0] act;
    logic [35:0] expv;
    exp_t        e;
    if_pc         = 32'h308;
    ex_valid      = 1'b1;
    ex_kill       = 1'b1;
    ex_pc         = 32'h308;
    a             = 32'h7;
    b             = 32'h7;
    funct3        = F3_BEQ;
    Jump          = 1'b0;
    ex_pred_taken = 1'b0;
    step();
    vectors++;
    if (res_valid !== 1'b0 || if_pred_taken !== 1'b0 || stat_branches !== m_br) begin
      miscompares++;
      $display("FAIL kill: got valid %b pred %b br %0d expected 0 0 %0d",
               res_valid, if_pred_taken, stat_branches, m_br);
    end
    for (int i = 0; i < 2; i++) begin
      drive_ex(32'h308, 32'h500, 32'h7, 32'h7, 3'(3'b010 + 3'(i)), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
      e    = sb.pop_front();
      act  = {res_valid, res_taken, res_mispredict, res_redirect, res_illegal};
      expv = {1'b1, e.taken, e.mispred, e.redirect, e.illegal};
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL illegal_res[%0d]: got %0h expected %0h", i, act, expv);
      end
      vectors++;
      if (stat_branches !== m_br || stat_mispred !== m_mp || if_pred_taken !== 1'b0) begin
        miscompares++;
        $display("FAIL illegal_side[%0d]: got %0d/%0d pred %b expected %0d/%0d pred 0",
                 i, stat_branches, stat_mispred, if_pred_taken, m_br, m_mp);
      end
    end
    if_pc = 32'h30C;
    drive_ex(32'h30C, 32'h600, 32'h9, 32'h9, F3_BEQ, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    vectors++;
    if (if_pred_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_old: got %b expected 0", if_pred_taken);
    end
    step();
    e = sb.pop_front();
    vectors++;
    if (if_pred_taken !== 1'b1 || res_taken !== e.taken) begin
      miscompares++;
      $display("FAIL collision_new: got pred %b taken %b expected 1 %b",
               if_pred_taken, res_taken, e.taken);
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] act;
    logic [35:0] expv;
    exp_t        e;
    exp_t        last;
    drive_ex(32'h410, 32'h900, 32'hFFFFFFFF, 32'h1, F3_BLT, 1'b0, 1'b0, m_bht[4][1], 1'b1, 1'b0);
    @(posedge clk);
    #1;
    e    = sb.pop_front();
    act  = {res_valid, res_taken, res_mispredict, res_redirect, res_illegal};
    expv = {1'b1, e.taken, e.mispred, e.redirect, e.illegal};
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL b2b_first: got %0h expected %0h", act, expv);
    end
    drive_ex(32'h414, 32'hA00, 32'h3, 32'h80000000, F3_BGE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    last = sb.pop_front();
    act  = {res_valid, res_taken, res_mispredict, res_redirect, res_illegal};
    expv = {1'b1, last.taken, last.mispred, last.redirect, last.illegal};
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL b2b_second: got %0h expected %0h", act, expv);
    end
    @(posedge clk);
    #1;
    act  = {res_valid, res_taken, res_mispredict, res_redirect, res_illegal};
    expv = {1'b0, last.taken, last.mispred, last.redirect, last.illegal};
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL b2b_hold: got %0h expected %0h", act, expv);
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    drive_ex(32'h100, 32'h700, 32'h1, 32'h1, F3_BEQ, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    if_pc = 32'h100;
    #1;
    vectors++;
    if (res_valid !== 1'b0 || stat_branches !== 32'd0 || stat_mispred !== 32'd0 ||
        if_pred_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: got valid %b br %0d mp %0d pred %b expected 0 0 0 0",
               res_valid, stat_branches, stat_mispred, if_pred_taken);
    end
    drive_ex(32'h100, 32'h700, 32'h1, 32'h2, F3_BNE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    e = sb.pop_front();
    vectors++;
    if (res_valid !== 1'b1 || res_taken !== e.taken || stat_branches !== 32'd1 ||
        stat_mispred !== 32'd1) begin
      miscompares++;
      $display("FAIL rst_recover: got valid %b taken %b br %0d mp %0d expected 1 1 1 1",
               res_valid, res_taken, stat_branches, stat_mispred);
    end
  endtask

  initial begin
    rst           = 1'b1;
    if_pc         = 32'h0;
    ex_valid      = 1'b0;
    ex_kill       = 1'b0;
    ex_pc         = 32'h0;
    ex_target     = 32'h0;
    a             = 32'h0;
    b             = 32'h0;
    funct3        = 3'b000;
    Jump          = 1'b0;
    BrUn          = 1'b0;
    ex_pred_taken = 1'b0;
    model_reset();
    test_reset();
    test_compare_matrix();
    test_training();
    test_jump_redirect();
    test_kill_illegal_collision();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
